// File: rtl/hazard_pkg.sv
// Types and encodings for the EX-stage hazard controller.
package hazard_pkg;

  // Multi-cycle tracker states.
  typedef enum logic {
    IDLE    = 1'b0,
    MC_WAIT = 1'b1
  } state_e;

  // df_sel value that keeps the register-file operand.
  localparam int DF_RF = 0;

  // df_sel value that picks downstream stage k (0 = MEM).
  function automatic int df_stage(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/reg_names.sv
// Architectural register naming shared across the RISC-V core.
package reg_names;

  typedef logic [4:0] regName_t;

  // x0 is hard-wired to zero and never carries a real dependency.
  localparam regName_t REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals exchanged with the hazard controller.
interface hazard_ctrl_if #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
);

  // ID stage
  reg_names::regName_t [NUM_SRC-1:0] id_rs;
  logic [NUM_SRC-1:0]                id_rs_used;
  // EX stage
  reg_names::regName_t [NUM_SRC-1:0] ex_rs;
  reg_names::regName_t               ex_rd;
  logic                              ex_regWrite;
  logic                              ex_memRead;
  // Downstream stages, index 0 nearest
  reg_names::regName_t [NUM_FWD-1:0] fwd_rd;
  logic [NUM_FWD-1:0]                fwd_regWrite;
  // Multi-cycle unit
  logic                              mc_start;
  logic                              mc_done;
  // Controller outputs
  logic [NUM_SRC-1:0][SEL_W-1:0]     df_sel;
  logic                              stall_if;
  logic                              stall_id;
  logic                              bubble_ex;
  logic                              mc_busy;
  logic                              mc_timeout;

  // Pipeline drives the hazard inputs and consumes the controls.
  modport master (
    output id_rs, id_rs_used, ex_rs, ex_rd, ex_regWrite, ex_memRead,
           fwd_rd, fwd_regWrite, mc_start, mc_done,
    input  df_sel, stall_if, stall_id, bubble_ex, mc_busy, mc_timeout
  );

  // Hazard controller side.
  modport slave (
    input  id_rs, id_rs_used, ex_rs, ex_rd, ex_regWrite, ex_memRead,
           fwd_rd, fwd_regWrite, mc_start, mc_done,
    output df_sel, stall_if, stall_id, bubble_ex, mc_busy, mc_timeout
  );

endinterface

// File: rtl/fwd_select.sv
// Priority encoder choosing the forwarding source for one EX operand.
module fwd_select
  import hazard_pkg::*;
  import reg_names::*;
#(
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  regName_t                rs,
  input  regName_t [NUM_FWD-1:0]  fwd_rd,
  input  logic     [NUM_FWD-1:0]  fwd_regWrite,
  output logic     [SEL_W-1:0]    sel
);

  // Scan oldest to nearest so the nearest matching stage is written last and wins.
  always_comb begin
    // NOTE: a default assignment before any conditional keeps combinational
    // blocks from inferring latches.
    sel = SEL_W'(DF_RF);
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_regWrite[k] && (fwd_rd[k] != REG_X0) && (fwd_rd[k] == rs))
        sel = SEL_W'(df_stage(k));
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller beside EX: operand forwarding, load-use stalls and
// tracking of one outstanding multi-cycle operation with a watchdog.
module hazard_ctrl
  import hazard_pkg::*;
  import reg_names::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int NUM_FWD    = 2,
  parameter int MC_TIMEOUT = 64,
  parameter int SEL_W      = $clog2(NUM_FWD + 1)
) (
  input  logic          clk,
  input  logic          rstN,
  hazard_ctrl_if.slave  hif
);

  localparam int WD_W = $clog2(MC_TIMEOUT + 1);

  state_e                        state_q, state_d;
  regName_t                      pend_rd_q, pend_rd_d;
  logic [WD_W-1:0]               wd_cnt_q, wd_cnt_d;
  logic [NUM_SRC-1:0][SEL_W-1:0] df_sel_raw;
  logic                          load_use;
  logic                          raw_pend;
  logic                          struct_haz;

  // One priority encoder per source operand.
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_select #(
      .NUM_FWD (NUM_FWD),
      .SEL_W   (SEL_W)
    ) u_fwd_select (
      .rs           (hif.ex_rs[s]),
      .fwd_rd       (hif.fwd_rd),
      .fwd_regWrite (hif.fwd_regWrite),
      .sel          (df_sel_raw[s])
    );
  end

  // Tracker state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rstN) begin
      state_q   <= IDLE;
      pend_rd_q <= REG_X0;
      wd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  // Next state, pending destination and watchdog count.
  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    wd_cnt_d  = wd_cnt_q;
    case (state_q)
      IDLE: begin
        wd_cnt_d = '0;
        if (hif.mc_start) begin
          state_d   = MC_WAIT;
          pend_rd_d = hif.ex_rd;
        end
      end
      MC_WAIT: begin
        if (hif.mc_start && hif.mc_done) begin
          // Result retires while a new op issues: hand over to the new op.
          pend_rd_d = hif.ex_rd;
          wd_cnt_d  = '0;
        end else if (hif.mc_done) begin
          state_d   = IDLE;
          pend_rd_d = REG_X0;
          wd_cnt_d  = '0;
        end else if (wd_cnt_q < WD_W'(MC_TIMEOUT)) begin
          // A started op without mc_done is stalled upstream; pend_rd is kept.
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        pend_rd_d = REG_X0;
        wd_cnt_d  = '0;
      end
    endcase
  end

  // Hazard detection and output drive, all forced low while in reset.
  always_comb begin
    load_use   = 1'b0;
    raw_pend   = 1'b0;
    struct_haz = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (hif.ex_memRead && hif.ex_regWrite && (hif.ex_rd != REG_X0) &&
          hif.id_rs_used[s] && (hif.id_rs[s] == hif.ex_rd))
        load_use = 1'b1;
      // The result forwards from WB in the mc_done cycle, so no stall then.
      if ((state_q == MC_WAIT) && !hif.mc_done && hif.id_rs_used[s] &&
          (pend_rd_q != REG_X0) && (hif.id_rs[s] == pend_rd_q))
        raw_pend = 1'b1;
    end
    struct_haz = (state_q == MC_WAIT) && hif.mc_start && !hif.mc_done;

    hif.df_sel     = '0;
    hif.stall_if   = 1'b0;
    hif.stall_id   = 1'b0;
    hif.bubble_ex  = 1'b0;
    hif.mc_busy    = 1'b0;
    hif.mc_timeout = 1'b0;
    if (rstN) begin
      hif.df_sel     = df_sel_raw;
      hif.stall_if   = load_use | raw_pend | struct_haz;
      hif.stall_id   = load_use | raw_pend | struct_haz;
      hif.bubble_ex  = load_use | raw_pend | struct_haz;
      hif.mc_busy    = (state_q == MC_WAIT);
      hif.mc_timeout = (state_q == MC_WAIT) && (wd_cnt_q == WD_W'(MC_TIMEOUT - 1));
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the pipelined RISC-V core, sitting beside the EX stage. It generalises operand forwarding to NUM_SRC source operands and NUM_FWD downstream stages. It adds load-use stall generation and in-order tracking of one outstanding multi-cycle operation (mul/div), which needs a small state machine and a latency watchdog. Its outputs drive the EX operand muxes, the IF/ID stall enables and the ID/EX bubble insertion.

## Interface
Clock and reset are a single clock and a synchronous, active-low reset.

**Parameters**
- NUM_SRC, 2: source operands per instruction.
- NUM_FWD, 2: forwarding stages after EX. Index 0 is the nearest (MEM), index NUM_FWD-1 the oldest (WB).
- MC_TIMEOUT, 64: cycles before an outstanding multi-cycle op is flagged.
- SEL_W, $clog2(NUM_FWD+1): width of one forwarding select.

**Ports**
- clk, in, 1: clock.
- rstN, in, 1: synchronous active-low reset.
- id_rs, in, NUM_SRC×regName_t: ID-stage source registers.
- id_rs_used, in, NUM_SRC: ID source is actually read.
- ex_rs, in, NUM_SRC×regName_t: EX-stage source registers.
- ex_rd, in, regName_t: EX destination.
- ex_regWrite, in, 1: EX writes a register.
- ex_memRead, in, 1: EX is a load.
- fwd_rd, in, NUM_FWD×regName_t: destination register of each downstream stage.
- fwd_regWrite, in, NUM_FWD: write enable of each downstream stage.
- mc_start, in, 1: EX issues a multi-cycle op (destination ex_rd).
- mc_done, in, 1: the multi-cycle unit returns its result to WB this cycle.
- df_sel, out, NUM_SRC×SEL_W: 0 selects the register file; k selects stage k-1.
- stall_if, out, 1: hold PC.
- stall_id, out, 1: hold IF/ID.
- bubble_ex, out, 1: insert a NOP into ID/EX.
- mc_busy, out, 1: a multi-cycle op is outstanding.
- mc_timeout, out, 1: one-cycle pulse when the watchdog expires.

## Operation
**Forwarding** (combinational)
- For each source s: df_sel[s] = k+1 for the smallest k where fwd_regWrite[k], fwd_rd[k]≠0 and fwd_rd[k]==ex_rs[s]. Otherwise df_sel[s] = 0.
- The nearest stage wins, and x0 is never forwarded.

**Load-use hazard**
- Condition: ex_memRead && ex_regWrite && ex_rd≠0 && ∃s: id_rs_used[s] && id_rs[s]==ex_rd.
- Response: stall_if = stall_id = bubble_ex = 1 for exactly one cycle. The load then moves to MEM and is forwarded through stage 0.

**Multi-cycle tracking.** The state machine has two states, IDLE and MC_WAIT.
- IDLE → MC_WAIT when mc_start. On that transition, register pend_rd = ex_rd and clear wd_cnt.
- MC_WAIT → IDLE when mc_done. pend_rd is cleared.
- In MC_WAIT, wd_cnt increments, saturating at MC_TIMEOUT. mc_timeout pulses on the cycle wd_cnt reaches MC_TIMEOUT-1. The state stays in MC_WAIT after a timeout.
- RAW against a pending op: in MC_WAIT, if ∃s: id_rs_used[s] && pend_rd≠0 && id_rs[s]==pend_rd, assert stall_if, stall_id and bubble_ex.
- Structural hazard: mc_start in MC_WAIT without mc_done in the same cycle. Treat it as a structural stall (all three stall outputs set) and do not re-latch pend_rd.
- mc_start and mc_done in the same cycle while in MC_WAIT: accept the new op, stay in MC_WAIT, load the new pend_rd and reset wd_cnt.
- mc_busy = (state==MC_WAIT).
- Stall outputs are the OR of all hazard sources.

## Timing
- df_sel and the stall outputs are zero-latency combinational, from the inputs and the registered state.
- State, pend_rd and wd_cnt update on posedge clk.
- A RAW stall on a pending op clears in the cycle mc_done is high, because the result forwards from WB (stage NUM_FWD-1).
- Reset (rstN=0 at a clock edge, including mid-op):
  - state→IDLE, pend_rd→0, wd_cnt→0.
  - While rstN=0, all outputs are forced to 0.
  - mc_done arriving after reset is ignored.

## Structure
- regName_t comes from reg_names.
- Add a new package hazard_pkg holding the state enum (IDLE, MC_WAIT) and the df_sel encoding constants (DF_RF=0).
- One sub-module fits naturally: fwd_select. It is the per-operand priority encoder over NUM_FWD stages and is instantiated NUM_SRC times.

## Test plan
1. Forwarding priority: MEM and WB both write x5, ex_rs[0]=x5, fwd_regWrite=2'b11 → df_sel[0]=1. Drop MEM's write → df_sel[0]=2.
2. x0 guard: fwd_rd[0]=0 with write set, ex_rs[1]=0 → df_sel[1]=0.
3. Load-use: ex_memRead, ex_rd=x7, id_rs[1]=x7 used → one cycle of stall_if, stall_id and bubble_ex. Next cycle with the load in MEM: df_sel[1]=1 and no stall.
4. Multi-cycle RAW: mc_start with ex_rd=x10, then ID reads x10 → stall until mc_done at cycle 5. Stall drops in the mc_done cycle, df_sel selects WB, mc_busy returns to 0.
5. Watchdog: mc_start with no mc_done → mc_timeout is a single pulse 63 cycles after MC_WAIT entry (default MC_TIMEOUT=64), and mc_busy stays 1.
6. Reset mid-op: rstN=0 during MC_WAIT → all outputs 0. After release: mc_busy=0 and no stall on a read of the old pend_rd.
